// File: rtl/emissor_talao.sv
// emissor_talao: buffers BCD item records in a FIFO and prints them plus a tax footer
// as an ASCII byte stream over a valid/ready handshake.
module emissor_talao #(
    parameter int MAX_ITENS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         item_valid,
    input  logic [1:0]                   produto,
    input  logic [3:0]                   BCDkg_decimal,
    input  logic [11:0]                  BCDkg_fracionario,
    input  logic [7:0]                   BCDeuros_decimal,
    input  logic [7:0]                   BCDeuros_fracionario,
    input  logic                         emissao_talao,
    input  logic [4:0]                   valor_taxa,
    input  logic                         tx_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    output logic                         busy,
    output logic [$clog2(MAX_ITENS):0]   n_itens,
    output logic                         overflow
);
    localparam int AW = $clog2(MAX_ITENS);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LINHA, RODAPE, FIM} state_t;

    state_t        state_q, state_d;
    logic [33:0]   mem_q [MAX_ITENS];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    idx_q, idx_d;
    logic [4:0]    tax_q, tax_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          overflow_q, overflow_d;
    logic [33:0]   in_rec, head_rec, next_rec;
    logic          busy_w, full, push, pop, drop, xfer;

    function automatic logic [7:0] digit(input logic [3:0] n);
        return {4'h3, n};
    endfunction

    // Record layout: {produto, kg, kg fraction, euros, cents}
    function automatic logic [7:0] line_byte(input logic [33:0] r, input logic [3:0] i);
        logic [7:0] pc;
        pc = r[33:32] == 2'd1 ? 8'h42 : r[33:32] == 2'd2 ? 8'h4D :
             r[33:32] == 2'd3 ? 8'h54 : 8'h3F;
        case (i)
            4'd0:        line_byte = pc;
            4'd1, 4'd7:  line_byte = 8'h20;
            4'd2:        line_byte = digit(r[31:28]);
            4'd3, 4'd10: line_byte = 8'h2E;
            4'd4:        line_byte = digit(r[27:24]);
            4'd5:        line_byte = digit(r[23:20]);
            4'd6:        line_byte = digit(r[19:16]);
            4'd8:        line_byte = digit(r[15:12]);
            4'd9:        line_byte = digit(r[11:8]);
            4'd11:       line_byte = digit(r[7:4]);
            4'd12:       line_byte = digit(r[3:0]);
            default:     line_byte = 8'h0A;
        endcase
    endfunction

    function automatic logic [7:0] foot_byte(input logic [4:0] t, input logic [3:0] i);
        logic [1:0] tens;
        logic [3:0] units;
        tens  = t >= 5'd30 ? 2'd3 : t >= 5'd20 ? 2'd2 : t >= 5'd10 ? 2'd1 : 2'd0;
        units = 4'(t - 5'(tens) * 5'd10);
        case (i)
            4'd0:    foot_byte = 8'h58;
            4'd1:    foot_byte = 8'h20;
            4'd2:    foot_byte = digit({2'b00, tens});
            4'd3:    foot_byte = digit(units);
            default: foot_byte = 8'h0A;
        endcase
    endfunction

    assign in_rec   = {produto, BCDkg_decimal, BCDkg_fracionario, BCDeuros_decimal, BCDeuros_fracionario};
    assign head_rec = mem_q[rd_ptr_q];
    assign next_rec = mem_q[rd_ptr_q + AW'(1)];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tax_d      = tax_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        overflow_d = overflow_q;
        pop        = 1'b0;
        busy_w     = state_q != IDLE;
        full       = count_q == CW'(MAX_ITENS);
        push       = item_valid && !busy_w && !full;
        drop       = item_valid && (busy_w || full);
        xfer       = tx_valid_q && tx_ready;
        case (state_q)
            IDLE: if (emissao_talao) begin
                tax_d      = valor_taxa;
                idx_d      = 4'd0;
                tx_valid_d = 1'b1;
                // A record captured this very cycle heads the receipt when the FIFO is empty
                if (count_q != '0 || push) begin
                    state_d   = LINHA;
                    tx_data_d = line_byte(count_q != '0 ? head_rec : in_rec, 4'd0);
                end else begin
                    state_d   = RODAPE;
                    tx_data_d = foot_byte(valor_taxa, 4'd0);
                end
            end
            LINHA: if (xfer) begin
                if (idx_q == 4'd13) begin
                    pop   = 1'b1;
                    idx_d = 4'd0;
                    if (count_q == CW'(1)) begin
                        state_d   = RODAPE;
                        tx_data_d = foot_byte(tax_q, 4'd0);
                    end else begin
                        tx_data_d = line_byte(next_rec, 4'd0);
                    end
                end else begin
                    idx_d     = idx_q + 4'd1;
                    tx_data_d = line_byte(head_rec, idx_q + 4'd1);
                end
            end
            RODAPE: if (xfer) begin
                if (idx_q == 4'd4) begin
                    state_d    = FIM;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    idx_d      = 4'd0;
                end else begin
                    idx_d     = idx_q + 4'd1;
                    tx_data_d = foot_byte(tax_q, idx_q + 4'd1);
                end
            end
            FIM: begin
                state_d    = IDLE;
                overflow_d = 1'b0;
            end
        endcase
        // A drop in the FIM cycle must not be lost to the clear
        if (drop) overflow_d = 1'b1;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            tax_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            tax_q      <= tax_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_rec;
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = state_q != IDLE;
    assign n_itens  = count_q;
    assign overflow = overflow_q;
endmodule

// File: doc/emissor_talao.md
# emissor_talao

Receipt emitter stage downstream of the scale datapath (`esquema`). Each weighed item is presented once, as its already-converted BCD weight and BCD price. The block buffers these items in an internal FIFO. When the purchase closes (`emissao_talao`), it serialises the buffered items and a tax footer as an ASCII byte stream to the printer interface over a valid/ready handshake.

## Interface
- `MAX_ITENS`, 8: FIFO depth in item records; a power of 2, ≥2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `item_valid`  in  1  capture strobe; one item record is taken per cycle in which it is high.
- `produto`  in  2  product code: 1 banana, 2 maracujá, 3 tangerina, 0 none.
- `BCDkg_decimal`  in  4  BCD integer kg digit.
- `BCDkg_fracionario`  in  12  three BCD kg fraction digits, most significant digit in [11:8].
- `BCDeuros_decimal`  in  8  two BCD euro digits.
- `BCDeuros_fracionario`  in  8  two BCD cent digits.
- `emissao_talao`  in  1  print request; sampled only in IDLE.
- `valor_taxa`  in  5  binary tax value 0–31; latched at the start of printing.
- `tx_ready`  in  1  printer accepts a byte.
- `tx_data`  out  8  ASCII byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `busy`  out  1  printing in progress.
- `n_itens`  out  $clog2(MAX_ITENS)+1  FIFO occupancy.
- `overflow`  out  1  sticky flag: an item was dropped.

## Operation
- Item record: 34 bits (`produto` + 32 BCD bits), written to the FIFO on `item_valid`. Records are printed in capture order.
- FSM states: IDLE, LINHA, RODAPE, FIM.
- IDLE
  - Capture items.
  - If `emissao_talao` is high: latch `valor_taxa`, go to LINHA if `n_itens` > 0, otherwise go to RODAPE.
- LINHA: emit the 14-byte line for the FIFO head, in this order:
  - product char: `B` (0x42), `M` (0x4D), `T` (0x54), or `?` (0x3F) for code 0;
  - 0x20, kg digit, `.` (0x2E), three kg fraction digits;
  - 0x20, two euro digits, `.`, two cent digits;
  - LF (0x0A).
  - After the LF handshake: pop the head. If the FIFO is now empty, go to RODAPE; otherwise repeat LINHA.
- RODAPE: emit 5 bytes: `X` (0x58), 0x20, tax tens digit, tax units digit, LF. Tax tens = 3/2/1/0 for values ≥30/≥20/≥10/<10; units = value − 10·tens. Then go to FIM.
- FIM: one cycle. Clear `overflow`, go to IDLE.
- Digit encoding: byte = 0x30 | nibble. There is no BCD validity check; nibbles above 9 yield 0x3A–0x3F.
- Drops: `item_valid` while the FIFO is full, or while `busy`, discards the record and sets `overflow`.
- Simultaneous `item_valid` and `emissao_talao` in IDLE: the item is captured and included in the receipt.
- `emissao_talao` is ignored while `busy`.

## Timing
- Reset (asynchronous, `rst`=0): state IDLE; FIFO empty; `n_itens`=0; `tx_valid`=0; `tx_data`=0x00; `busy`=0; `overflow`=0; latched tax = 0. Reset asserted mid-print aborts immediately; no partial bytes follow reset release.
- Handshake
  - A byte transfers on a rising edge where `tx_valid`=1 and `tx_ready`=1.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_valid` hold.
  - `tx_valid` never drops before its transfer completes.
  - `tx_data` is registered.
- Latency
  - Request sampled at edge t: `busy`=1 and the first byte is valid from t+1.
  - With `tx_ready` held at 1, one byte transfers per cycle, for a total of 14·n + 5 bytes.
  - FIM is the cycle after the last handshake. `busy` is high from t+1 through FIM, and low in the cycle after FIM.
- `n_itens` updates the cycle after a capture or pop.
- `overflow` sets the cycle after a drop and stays set until FIM or reset.

## Test plan
- Capture and print one item:
  - Stimulus: `item_valid` pulse with `produto`=1, kg `0`/`0x500`, euros `0x02`/`0x50`; then `emissao_talao`, `valor_taxa`=5, `tx_ready`=1.
  - Required: bytes `B 0.500 02.50\n` then `X 05\n`; 19 bytes on consecutive cycles; `busy` falls after FIM.
- Four items in order (codes 1, 2, 3, 3; prices 02.50, 01.50, 00.50, 00.50), then print with `valor_taxa`=23:
  - Required: four lines in capture order, then `X 23\n`; 61 bytes; `n_itens` 4→0.
- Backpressure: toggle `tx_ready` 1/0 every cycle during print.
  - Required: each byte holds stable while `tx_ready`=0; output sequence identical to the unstalled case; no byte lost or duplicated.
- Overflow:
  - Stimulus: push `MAX_ITENS`+1 items; then an item arriving mid-print.
  - Required: `overflow`=1; only `MAX_ITENS` lines printed; `overflow`=0 after FIM.
- Empty print: `emissao_talao` with an empty FIFO and `valor_taxa`=31.
  - Required: only `X 31\n`.
- Reset during the third byte of a line:
  - Required: `tx_valid`=0 immediately; `n_itens`=0; state IDLE; no bytes emitted after release.
